gcd_datapath: RTL and testbench
===============================

Name: gcd_datapath

Overview:
- Operand/arithmetic datapath that pairs with the GCD control FSM, which supplies load/compute/done and consumes cpr.
- Registers two operands on load and runs subtract-based Euclid, one step per compute cycle.
- Reports the comparator code back to the FSM every cycle; captures and holds the result once done is seen.
- Also provides an iteration counter and zero-operand detection, so the FSM never hangs on a zero input.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CNT_W, 16, iteration counter width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  from FSM: capture a_in/b_in this cycle.
- compute  input  1  from FSM: perform one Euclid step this cycle.
- done  input  1  from FSM: computation finished; capture the result.
- a_in  input  WIDTH  operand A; sampled only when load=1.
- b_in  input  WIDTH  operand B; sampled only when load=1.
- cpr  output  2  comparator code: 00 ra>rb, 01 ra<rb, 10 equal or terminal; 11 never driven.
- result  output  WIDTH  GCD value; valid while result_valid=1.
- result_valid  output  1  result holds the GCD of the last loaded pair.
- iter_count  output  CNT_W  subtraction steps taken since the last load; saturating.
- zero_operand  output  1  at least one registered operand is zero.

Behaviour:
- Internal state: ra, rb (WIDTH), result_r, valid_r, cnt.
- Reset (rst_n=0, async): ra=rb=0, result=0, result_valid=0, iter_count=0. Derived outputs then read zero_operand=1, cpr=10.
- cpr, zero_operand: combinational from ra/rb only; no combinational path from a_in, b_in, load, compute or done.
  - zero_operand = (ra==0)|(rb==0).
  - cpr = 10 if zero_operand or ra==rb; else 00 if ra>rb; else 01.
- Load cycle (load=1):
  - ra<=a_in, rb<=b_in, cnt<=0, valid_r<=0.
  - result holds its old value but is invalid.
  - load has priority over compute and done in the same cycle.
- Compute cycle (compute=1, load=0):
  - cpr=00: ra<=ra-rb. cpr=01: rb<=rb-ra. cpr=10: ra/rb hold.
  - Subtraction is unsigned WIDTH-bit and never underflows, because the larger operand is always the minuend.
  - cnt increments only when cpr!=10 and cnt!=all-ones; it saturates at 2^CNT_W-1.
- Done cycle (done=1, load=0, valid_r=0):
  - result<=(ra==0)?rb:ra; valid_r<=1.
  - gcd(x,0)=x and gcd(0,0)=0.
  - Later done cycles hold result; no recapture.
- Idle (no strobes): all registers hold.
- compute and done high together (load=0): the done capture uses the pre-step ra/rb. When cpr=10 the values are unchanged, so this is harmless.
- Latency with the FSM:
  - FSM LOAD, then the first CALC cycle sees the registered operands.
  - N subtraction steps produce cpr=10 at CALC cycle N+1.
  - FSM enters DONE the next cycle; result_valid rises one cycle after that.
- Reset mid-operation: immediate return to reset values. The FSM is also reset and restarts with a fresh load.
- The FSM never sees cpr=11; synthesis must not create a path producing it.

Test Plan:
- rst_n low → cpr=10, result_valid=0, iter_count=0. Release rst_n, then load a_in=48, b_in=18, run compute until cpr=10 → iter_count=4 (48/18→30/18→12/18→12/6→6/6). Pulse done → result=6, result_valid=1 one cycle after the done cycle.
- Load 13,13 → cpr=10 on the first compute cycle, iter_count=0. Done → result=13.
- Load 7,0 → zero_operand=1, cpr=10 immediately, iter_count=0. Done → result=7. Load 0,0 → result=0.
- CNT_W=8: load 1,300, compute until cpr=10 → 299 steps, iter_count saturates at 255, result=1. Next load clears iter_count to 0 and result_valid to 0.
- Assert load and compute together with 20,8 → registers take 20,8 with no subtraction. Assert rst_n low mid-computation of 48,18 → all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/gcd_datapath.sv
// Operand/arithmetic datapath for subtract-based Euclid GCD, steered by an external control FSM.
// Latency: one Euclid step per compute cycle; result_valid rises one cycle after the done cycle.
// No backpressure: strobes act in the cycle they are seen. load beats compute and done.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   load/compute/done   FSM strobes: capture operands / one subtraction step / capture result
//   a_in, b_in          operands, sampled only while load=1
//   cpr                 comparator code to the FSM: 00 ra>rb, 01 ra<rb, 10 equal or terminal
//   result              GCD of the last loaded pair, meaningful while result_valid=1
//   iter_count          saturating count of subtraction steps since the last load
//   zero_operand        at least one registered operand is zero
module gcd_datapath #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             compute,
   input  logic             done,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [1:0]       cpr,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [CNT_W-1:0] iter_count,
   output logic             zero_operand
);

   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] result_r;
   logic             valid_r;
   logic [CNT_W-1:0] cnt;

   logic             terminal;
   logic             a_gt_b;
   logic             step;
   logic             cnt_max;

   // Comparator: a function of the registered operands only, so the FSM
   // never sees a combinational path from the operand inputs or strobes.
   // A zero operand is terminal: subtracting would never converge.
   always_comb begin
      zero_operand = (ra == '0) | (rb == '0);
      a_gt_b       = (ra > rb);
      terminal     = zero_operand | (ra == rb);
      // Built so the upper bit and lower bit can never both be set:
      // the 11 code is structurally unreachable.
      cpr          = {terminal, ~terminal & ~a_gt_b};
   end

   // A real subtraction happens only on a non-terminal compute cycle that
   // is not overridden by a simultaneous load.
   assign step    = compute & ~load & ~terminal;
   assign cnt_max = &cnt;

   // Operand registers. The larger operand is always the minuend, so the
   // unsigned subtraction cannot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra <= '0;
         rb <= '0;
      end else if (load) begin
         ra <= a_in;
         rb <= b_in;
      end else if (step) begin
         if (a_gt_b) begin
            ra <= ra - rb;
         end else begin
            rb <= rb - ra;
         end
      end
   end

   // Iteration counter, saturating so a long run never wraps back to a
   // small misleading value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (step && !cnt_max) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Result capture. Only the first done after a load captures; later done
   // cycles hold. When compute and done coincide the pre-step operands are
   // used, which is harmless because the FSM only raises done once cpr=10.
   // gcd(x,0)=x and gcd(0,0)=0 both fall out of picking rb when ra is zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= '0;
         valid_r  <= 1'b0;
      end else if (load) begin
         valid_r  <= 1'b0;
      end else if (done && !valid_r) begin
         result_r <= (ra == '0) ? rb : ra;
         valid_r  <= 1'b1;
      end
   end

   assign result       = result_r;
   assign result_valid = valid_r;
   assign iter_count   = cnt;

endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: two instances (CNT_W=16 and CNT_W=8) share the stimulus.
// A behavioural GCD model is checked against both every cycle; directed
// vectors also carry hand-computed literal expectations.
module tb_gcd_datapath;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load = 1'b0;
   logic         compute = 1'b0;
   logic         done = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;

   logic [1:0]   cpr16, cpr8;
   logic [W-1:0] res16, res8;
   logic         val16, val8;
   logic [15:0]  iter16;
   logic [7:0]   iter8;
   logic         zero16, zero8;

   int checks = 0;
   int failures = 0;

   gcd_datapath #(.WIDTH(W), .CNT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .load(load), .compute(compute), .done(done),
      .a_in(a_in), .b_in(b_in), .cpr(cpr16), .result(res16),
      .result_valid(val16), .iter_count(iter16), .zero_operand(zero16)
   );

   gcd_datapath #(.WIDTH(W), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .load(load), .compute(compute), .done(done),
      .a_in(a_in), .b_in(b_in), .cpr(cpr8), .result(res8),
      .result_valid(val8), .iter_count(iter8), .zero_operand(zero8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_a = 0, m_b = 0, m_res = 0;
   int          m_cnt = 0;
   bit          m_val = 1'b0;

   function automatic int unsigned exp_cpr(input int unsigned a, input int unsigned b);
      if (a == 0 || b == 0 || a == b) return 2;
      return (a > b) ? 0 : 1;
   endfunction

   function automatic int unsigned sat(input int c, input int unsigned maxv);
      return (c > int'(maxv)) ? maxv : int'(c);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_a = 0; m_b = 0; m_res = 0; m_cnt = 0; m_val = 1'b0;
      end else if (load) begin
         m_a = a_in; m_b = b_in; m_cnt = 0; m_val = 1'b0;
      end else begin
         if (done && !m_val) begin
            m_res = (m_a == 0) ? m_b : m_a;
            m_val = 1'b1;
         end
         if (compute && exp_cpr(m_a, m_b) != 2) begin
            if (m_a > m_b) m_a = m_a - m_b;
            else           m_b = m_b - m_a;
            m_cnt++;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("cpr16",  32'(cpr16),  exp_cpr(m_a, m_b));
      chk("cpr8",   32'(cpr8),   exp_cpr(m_a, m_b));
      chk("zero16", 32'(zero16), 32'(m_a == 0 || m_b == 0));
      chk("zero8",  32'(zero8),  32'(m_a == 0 || m_b == 0));
      chk("iter16", 32'(iter16), sat(m_cnt, 65535));
      chk("iter8",  32'(iter8),  sat(m_cnt, 255));
      chk("valid16", 32'(val16), 32'(m_val));
      chk("valid8",  32'(val8),  32'(m_val));
      chk("res16",  32'(res16),  m_res);
      chk("res8",   32'(res8),   m_res);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int unsigned a, input int unsigned b);
      a_in = W'(a);
      b_in = W'(b);
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic do_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic run_compute(input int limit);
      int n = 0;
      compute = 1'b1;
      while (cpr16 != 2'b10 && n < limit) begin
         tick();
         n++;
      end
      compute = 1'b0;
      chk("compute_terminates", 32'(cpr16), 32'd2);
   endtask

   initial begin
      rst_n = 1'b0;
      #3;
      chk("rst_cpr",   32'(cpr16), 32'd2);
      chk("rst_valid", 32'(val16), 32'd0);
      chk("rst_iter",  32'(iter16), 32'd0);
      chk("rst_zero",  32'(zero16), 32'd1);
      chk("rst_res",   32'(res16), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // 48,18: 48/18 -> 30/18 -> 12/18 -> 12/6 -> 6/6
      do_load(48, 18);
      chk("l48_cpr", 32'(cpr16), 32'd0);
      run_compute(50);
      chk("l48_iter", 32'(iter16), 32'd4);
      chk("l48_valid_pre", 32'(val16), 32'd0);
      do_done();
      chk("l48_valid", 32'(val16), 32'd1);
      chk("l48_res", 32'(res16), 32'd6);

      // equal operands: terminal at once
      do_load(13, 13);
      compute = 1'b1;
      tick();
      compute = 1'b0;
      chk("eq_cpr", 32'(cpr16), 32'd2);
      chk("eq_iter", 32'(iter16), 32'd0);
      do_done();
      chk("eq_res", 32'(res16), 32'd13);

      // zero operands
      do_load(7, 0);
      chk("z7_zero", 32'(zero16), 32'd1);
      chk("z7_cpr", 32'(cpr16), 32'd2);
      compute = 1'b1;
      tick();
      tick();
      compute = 1'b0;
      chk("z7_iter", 32'(iter16), 32'd0);
      do_done();
      chk("z7_res", 32'(res16), 32'd7);
      do_load(0, 0);
      do_done();
      chk("z0_res", 32'(res16), 32'd0);
      chk("z0_valid", 32'(val16), 32'd1);

      // long run: 299 steps, 8-bit counter saturates
      do_load(1, 300);
      run_compute(400);
      chk("long_iter16", 32'(iter16), 32'd299);
      chk("long_iter8",  32'(iter8),  32'd255);
      do_done();
      chk("long_res16", 32'(res16), 32'd1);
      chk("long_res8",  32'(res8),  32'd1);
      do_load(5, 3);
      chk("reload_iter8", 32'(iter8), 32'd0);
      chk("reload_valid", 32'(val8), 32'd0);

      // load and compute together: no subtraction, result is the raw 20
      a_in = 16'd20;
      b_in = 16'd8;
      load = 1'b1;
      compute = 1'b1;
      tick();
      load = 1'b0;
      compute = 1'b0;
      chk("lc_iter", 32'(iter16), 32'd0);
      chk("lc_cpr", 32'(cpr16), 32'd0);
      do_done();
      chk("lc_res", 32'(res16), 32'd20);

      // compute and done together: capture sees pre-step operands
      do_load(48, 18);
      compute = 1'b1;
      done = 1'b1;
      tick();
      compute = 1'b0;
      done = 1'b0;
      chk("cd_res", 32'(res16), 32'd48);
      chk("cd_iter", 32'(iter16), 32'd1);

      // asynchronous reset mid-computation
      do_load(48, 18);
      compute = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cpr",   32'(cpr16), 32'd2);
      chk("arst_zero",  32'(zero16), 32'd1);
      chk("arst_iter",  32'(iter16), 32'd0);
      chk("arst_valid", 32'(val16), 32'd0);
      chk("arst_res",   32'(res16), 32'd0);
      compute = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
